// File: rtl/jt10_adpcm_pkg.sv
// Shared definitions for the ADPCM-A ROM fetch path.
//   ROM_AW       : full ROM byte address width ({bank,addr})
//   LATE_CYC_DEF : default cycle budget from issue to SDRAM ok
//   state_t      : fetch FSM states
package jt10_adpcm_pkg;

    localparam int ROM_AW       = 24;
    localparam int LATE_CYC_DEF = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/jt10_adpcma_bytecache.sv
// Small fully-associative byte cache in front of the ADPCM-A ROM.
// Lookup is combinational over all tags; fills replace entries round-robin.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset (flushes valid bits and pointer)
//   key      [23:0]  : lookup address
//   hit, hit_data    : lookup result (hit_data is 0 on a miss)
//   wr               : write {wr_key, wr_data} into the entry at the replacement pointer
//   wr_key   [23:0]  : tag to store
//   wr_data  [7:0]   : byte to store
module jt10_adpcma_bytecache
    import jt10_adpcm_pkg::*;
#(
    parameter int CACHE_N = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ROM_AW-1:0] key,
    output logic              hit,
    output logic [7:0]        hit_data,
    input  logic              wr,
    input  logic [ROM_AW-1:0] wr_key,
    input  logic [7:0]        wr_data
);

    localparam int PTR_W = (CACHE_N > 1) ? $clog2(CACHE_N) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(CACHE_N - 1);

    logic [ROM_AW-1:0] tag [CACHE_N];
    logic [7:0]        dat [CACHE_N];
    logic [CACHE_N-1:0] vld;
    logic [PTR_W-1:0]   ptr;

    // A key is only ever stored once, so at most one entry can match.
    always_comb begin
        hit      = 1'b0;
        hit_data = 8'd0;
        for (int i = 0; i < CACHE_N; i++) begin
            if (vld[i] && tag[i] == key) begin
                hit      = 1'b1;
                hit_data = dat[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            ptr <= '0;
        end else if (wr) begin
            vld[ptr] <= 1'b1;
            ptr      <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        end
    end

    // Tag/data storage needs no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (wr) begin
            tag[ptr] <= wr_key;
            dat[ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/jt10_adpcma_romfetch.sv
// Bridges the ADPCM-A driver ROM strobe (addr/bank/roe_n) to an SDRAM req/ok port,
// with a small byte cache, one outstanding request and a one-deep pending slot.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   cen               : clock enable qualifying roe_n sampling
//   addr[19:0], bank[3:0], roe_n : driver ROM strobe; key = {bank,addr}
//   datain[7:0]       : byte returned to the driver
//   rom_addr[23:0], rom_req, rom_ok, rom_data[7:0] : SDRAM-side handshake
//   late, overrun     : sticky status flags
//   clr_st            : clears the status flags (a simultaneous set wins)
module jt10_adpcma_romfetch
    import jt10_adpcm_pkg::*;
#(
    parameter int CACHE_N  = 6,
    parameter int LATE_CYC = LATE_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic [19:0]       addr,
    input  logic [3:0]        bank,
    input  logic              roe_n,
    output logic [7:0]        datain,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_req,
    input  logic              rom_ok,
    input  logic [7:0]        rom_data,
    output logic              late,
    output logic              overrun,
    input  logic              clr_st
);

    // Counter saturates at all-ones, which is always above LATE_CYC,
    // so the equality that raises late happens on exactly one cycle.
    localparam int CNT_W = $clog2(LATE_CYC + 2);
    localparam logic [CNT_W-1:0] LATE_V = CNT_W'(LATE_CYC);

    state_t            state;
    logic              roe_last;
    logic              pend_vld;
    logic [ROM_AW-1:0] pend_key;
    logic [CNT_W-1:0]  cnt;

    logic              strobe;
    logic [ROM_AW-1:0] skey;
    logic [ROM_AW-1:0] lk_key;
    logic              hit;
    logic [7:0]        hit_data;
    logic              fill;
    logic              req_new;
    logic              gap_new;

    assign strobe = cen & roe_last & ~roe_n;
    assign skey   = {bank, addr};
    // GAP re-checks the pending key; any strobe in that cycle is deferred.
    assign lk_key = (state == ST_GAP) ? pend_key : skey;
    assign fill   = (state == ST_REQ) & rom_ok;
    // In REQ a strobe needs the pending slot only if it is neither cached nor in flight.
    assign req_new = strobe & ~hit & (skey != rom_addr);
    assign gap_new = strobe & (skey != pend_key);

    jt10_adpcma_bytecache #(
        .CACHE_N (CACHE_N)
    ) u_cache (
        .clk      (clk),
        .rst_n    (rst_n),
        .key      (lk_key),
        .hit      (hit),
        .hit_data (hit_data),
        .wr       (fill),
        .wr_key   (rom_addr),
        .wr_data  (rom_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            roe_last <= 1'b1;
            pend_vld <= 1'b0;
            pend_key <= '0;
            cnt      <= '0;
            datain   <= 8'd0;
            rom_addr <= '0;
            rom_req  <= 1'b0;
            late     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (cen) roe_last <= roe_n;

            // Placed first so that set conditions below override a clear.
            if (clr_st) begin
                late    <= 1'b0;
                overrun <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (strobe) begin
                        if (hit) begin
                            datain <= hit_data;
                        end else begin
                            rom_addr <= skey;
                            rom_req  <= 1'b1;
                            cnt      <= '0;
                            state    <= ST_REQ;
                        end
                    end
                end

                ST_REQ: begin
                    if (cnt != '1) cnt <= cnt + 1'b1;
                    if (cnt == LATE_V && !rom_ok) late <= 1'b1;

                    if (rom_ok) begin
                        datain  <= rom_data;
                        rom_req <= 1'b0;
                        state   <= (pend_vld || req_new) ? ST_GAP : ST_IDLE;
                    end

                    // A hit from the newer strobe takes precedence over the fill data.
                    if (strobe && hit) datain <= hit_data;

                    if (req_new) begin
                        pend_key <= skey;
                        pend_vld <= 1'b1;
                        if (pend_vld && pend_key != skey) overrun <= 1'b1;
                    end
                end

                ST_GAP: begin
                    if (hit) begin
                        datain <= hit_data;
                        state  <= gap_new ? ST_GAP : ST_IDLE;
                    end else begin
                        rom_addr <= pend_key;
                        rom_req  <= 1'b1;
                        cnt      <= '0;
                        state    <= ST_REQ;
                    end
                    pend_vld <= gap_new;
                    if (gap_new) pend_key <= skey;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
